// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port data RAM arbiter.
// Included by the arbiter top and its round-robin sub-module.
package ram_arbiter_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_SERVE = 1'b1
    } state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin arbiter: one-hot grant, the port that
// did not win last time takes a tie.
module rr_arbiter_2
    import ram_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // grant selection; port 0 wins a tie only when port 1 was served last
    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || (last == PORT1))) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end else begin
            gnt = 2'b00;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-write / async-read RAM between the CPU port (0) and the
// loader/debug port (1); zero-fills the RAM after every reset.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  init_done
);

    localparam logic [ADDR_WIDTH-1:0] CNT_MAX  = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    state_e                  state_r;
    state_e                  state_s;
    logic [ADDR_WIDTH-1:0]   cnt_r;
    logic                    last_r;
    logic                    ack0_r;
    logic                    ack1_r;
    logic [DATA_WIDTH-1:0]   rdata0_r;
    logic [DATA_WIDTH-1:0]   rdata1_r;
    logic                    init_done_r;
    logic [1:0]              arb_gnt_s;

    rr_arbiter_2 u_rr (
        .req  ({req1, req0}),
        .last (last_r),
        .gnt  (arb_gnt_s)
    );

    // next state plus the grant and RAM pin drive; reset forces everything quiet
    always_comb begin
        state_s     = state_r;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        mem_we      = 1'b0;
        mem_address = ADDR_ZERO;
        mem_data_in = DATA_ZERO;
        case (state_r)
            ST_INIT: begin
                if (cnt_r == CNT_MAX) begin
                    state_s = ST_SERVE;
                end else begin
                    state_s = ST_INIT;
                end
                if (rst_n) begin
                    mem_we      = 1'b1;
                    mem_address = cnt_r;
                end else begin
                    mem_we      = 1'b0;
                end
            end
            ST_SERVE: begin
                state_s = ST_SERVE;
                if (!rst_n) begin
                    gnt0 = 1'b0;
                    gnt1 = 1'b0;
                end else if (arb_gnt_s[0]) begin
                    gnt0        = 1'b1;
                    mem_we      = we0;
                    mem_address = addr0;
                    mem_data_in = wdata0;
                end else if (arb_gnt_s[1]) begin
                    gnt1        = 1'b1;
                    mem_we      = we1;
                    mem_address = addr1;
                    mem_data_in = wdata1;
                end else begin
                    mem_we = 1'b0;
                end
            end
            default: begin
                state_s = ST_INIT;
            end
        endcase
    end

    // state, fill counter, round-robin history and completion registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_INIT;
            cnt_r       <= ADDR_ZERO;
            last_r      <= PORT1;
            ack0_r      <= 1'b0;
            ack1_r      <= 1'b0;
            rdata0_r    <= DATA_ZERO;
            rdata1_r    <= DATA_ZERO;
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            init_done_r <= (state_s == ST_SERVE);
            if (state_r == ST_INIT) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
            ack0_r <= gnt0;
            ack1_r <= gnt1;
            // RAM read is asynchronous, so capture gives pre-write contents
            if (gnt0) begin
                rdata0_r <= mem_data_out;
                last_r   <= PORT0;
            end else if (gnt1) begin
                rdata1_r <= mem_data_out;
                last_r   <= PORT1;
            end else begin
                last_r   <= last_r;
            end
        end
    end

    assign ack0      = ack0_r;
    assign ack1      = ack1_r;
    assign rdata0    = rdata0_r;
    assign rdata1    = rdata1_r;
    assign init_done = init_done_r;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-write / async-read data RAM between two requesters: port 0 is the CPU load/store path and port 1 is the loader/debug path.
- After reset, zero-fills every RAM word, then serves one transaction per cycle with round-robin arbitration.
- Sits between the requesters and the RAM's address / data_in / write_enable / data_out pins.

Parameters:
- DATA_WIDTH, 32, width of RAM word and of all data ports.
- ADDR_WIDTH, 5, RAM address width; depth = 2**ADDR_WIDTH words.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req0  in  1  port 0 request, level-held until granted.
- we0  in  1  port 0 write (1) / read (0).
- addr0  in  ADDR_WIDTH  port 0 word address.
- wdata0  in  DATA_WIDTH  port 0 write data.
- gnt0  out  1  combinational grant to port 0; the transaction executes this cycle.
- ack0  out  1  registered one-cycle pulse, the cycle after gnt0.
- rdata0  out  DATA_WIDTH  registered read data, valid while ack0 is high.
- req1, we1, addr1, wdata1, gnt1, ack1, rdata1: same as port 0, for port 1.
- mem_address  out  ADDR_WIDTH  to RAM address.
- mem_data_in  out  DATA_WIDTH  to RAM data_in.
- mem_we  out  1  to RAM write_enable.
- mem_data_out  in  DATA_WIDTH  from RAM data_out (asynchronous read).
- init_done  out  1  high once the zero-fill is complete.

Behaviour:
- Reset is synchronous and active-low: sampled only on the rising edge of clk; the block is in reset while rst_n is low at an edge.
- Reset state:
  - state = INIT, fill counter = 0, last_grant = 1 (port 0 wins the first tie).
  - ack0 = ack1 = 0; rdata0 = rdata1 = 0; init_done = 0.
- While rst_n is low: gnt0 = gnt1 = 0 and mem_we = 0 combinationally, so the RAM is never written.
- INIT state:
  - Drives mem_we = 1, mem_address = counter, mem_data_in = 0.
  - Counter increments every cycle.
  - On the edge where counter == 2**ADDR_WIDTH-1: that last write completes, state becomes SERVE and init_done = 1.
  - INIT lasts exactly 2**ADDR_WIDTH cycles (32 by default).
  - gnt0 = gnt1 = 0 throughout; requests are held off, not dropped.
- SERVE state:
  - Exactly one of gnt0/gnt1 is high whenever either req is high.
  - Only one request high: grant it.
  - Both high: grant the port that is not last_grant.
  - last_grant updates to the granted port on the edge of every grant; it is unchanged on idle cycles.
- Granted cycle:
  - mem_address = addrN, mem_data_in = wdataN, mem_we = weN.
  - The RAM writes on the closing edge.
- Idle SERVE cycle: mem_we = 0, mem_address = 0, mem_data_in = 0.
- Completion:
  - On the edge closing a grant, ackN <= 1 and rdataN <= mem_data_out.
  - Read latency: 1 cycle from gnt to data.
  - For a write, rdataN returns the pre-write contents (read-before-write).
- ackN returns to 0 unless the same port is granted again that cycle. Back-to-back grants give continuous ack.
- rdataN holds its last value when ackN is low.
- Requester rules:
  - Hold req/we/addr/wdata stable until gnt is seen.
  - Drop req, or present the next transaction, in the cycle after gnt.
  - A request still high after its grant is a new transaction.
- Same-address hazard: a read granted the cycle after a write to the same address returns the new data (RAM already updated).
- Reset mid-operation: pending acks are cancelled (ack0 = ack1 = 0 next cycle) and INIT restarts from address 0. This applies even from INIT part-way through.

Decomposition:
- Package ram_arbiter_pkg:
  - State encoding ST_INIT = 1'b0, ST_SERVE = 1'b1.
  - Port index constants PORT0 = 1'b0, PORT1 = 1'b1.
- Sub-module rr_arbiter_2:
  - Combinational 2-way round-robin: inputs req[1:0] and last; output one-hot gnt[1:0].
  - last_grant register stays in the parent.

Test Plan:
- Reset then idle: rst_n low 2 cycles, release. Expect mem_we = 1 for exactly 32 cycles with mem_address 0..31 and mem_data_in = 0, then init_done = 1 and mem_we = 0.
- Request during INIT: req0 = 1, we0 = 1, addr0 = 5, wdata0 = 32'hDEAD_BEEF at cycle 3 of INIT. gnt0 stays 0 until the first SERVE cycle, then the write occurs and ack0 pulses the next cycle.
- Write then read: port 0 writes 32'h1234_5678 to address 7, next cycle reads address 7. ack0 is high 2 cycles; the read ack gives rdata0 = 32'h1234_5678; the write ack gives rdata0 = 0.
- Contention: req0 and req1 held high 4 cycles, both reads. Grants go 0,1,0,1 and ack0/ack1 alternate one cycle later.
- Read-before-write: address 3 holds 32'hA5A5_A5A5; port 1 writes 32'h0F0F_0F0F to it. ack1 gives rdata1 = 32'hA5A5_A5A5; a later read gives 32'h0F0F_0F0F.
- Mid-operation reset: rst_n low for 1 cycle while gnt1 is high. Next cycle ack1 = 0, rdata1 = 0, init_done = 0, and INIT restarts at mem_address = 0. Previously written data is zeroed after 32 cycles.
